// File: rtl/snake_pkg.sv
// snake_pkg
//   Shared types and constants for the snake body engine.
//   - dir_t    : heading encoding (00 up, 01 right, 10 down, 11 left)
//   - state_t  : engine control states
//   - opposite : heading pointing the other way along the same axis
//   - XW/YW/LW : widths of pixel x, pixel y and segment count
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        DOWN  = 2'b10,
        LEFT  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MOVE  = 2'b01,
        CHECK = 2'b10,
        DRAW  = 2'b11
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int XW = 10;
    localparam int YW = 9;
    localparam int LW = 7;

    // Flipping the upper bit swaps up<->down and right<->left.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_cell_scanner.sv
// snake_cell_scanner
//   Walks one CELL x CELL square row-major (px fastest) and presents each
//   pixel on a registered valid/ready output. A start pulse loads a new
//   cell origin and presents its first pixel on the following cycle.
//   Ports:
//     draw_clk, reset      clock, asynchronous active-high reset
//     start                load org_x/org_y/last_cell and begin a cell
//     org_x, org_y         pixel origin of the cell
//     last_cell            this cell is the final one of the stream
//     px_ready             downstream accepts the current pixel
//     px_valid, rx, ry     registered pixel output
//     px_last              final pixel of the final cell
//     cell_done            final pixel of this cell accepted this cycle
module snake_cell_scanner
    import snake_pkg::*;
#(
    parameter int CELL = 10
) (
    input  logic          draw_clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] org_x,
    input  logic [YW-1:0] org_y,
    input  logic          last_cell,
    input  logic          px_ready,
    output logic          px_valid,
    output logic [XW-1:0] rx,
    output logic [YW-1:0] ry,
    output logic          px_last,
    output logic          cell_done
);

    localparam logic [3:0] CMAX = 4'(CELL - 1);

    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [3:0]    px;
    logic [3:0]    py;
    logic [3:0]    nx;
    logic [3:0]    ny;
    logic          is_last;
    logic          accept;

    assign accept    = px_valid && px_ready;
    assign cell_done = accept && (px == CMAX) && (py == CMAX);

    always_comb begin
        nx = px + 4'd1;
        ny = py;
        if (px == CMAX) begin
            nx = 4'd0;
            ny = py + 4'd1;
        end
    end

    always_ff @(posedge draw_clk or posedge reset) begin
        if (reset) begin
            ox       <= '0;
            oy       <= '0;
            px       <= '0;
            py       <= '0;
            is_last  <= 1'b0;
            px_valid <= 1'b0;
            rx       <= '0;
            ry       <= '0;
            px_last  <= 1'b0;
        end else if (start) begin
            ox       <= org_x;
            oy       <= org_y;
            px       <= '0;
            py       <= '0;
            is_last  <= last_cell;
            px_valid <= 1'b1;
            rx       <= org_x;
            ry       <= org_y;
            px_last  <= last_cell && (CMAX == 4'd0);
        end else if (accept) begin
            if (cell_done) begin
                px_valid <= 1'b0;
                px_last  <= 1'b0;
            end else begin
                px      <= nx;
                py      <= ny;
                rx      <= ox + XW'(nx);
                ry      <= oy + YW'(ny);
                px_last <= is_last && (nx == CMAX) && (ny == CMAX);
            end
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Holds up to MAX_LEN snake segments as grid cells, advances the body one
//   cell per step (with optional growth, reversal rejection and wrap or wall
//   kill), scans the new head against the body one segment per cycle, and
//   streams every body pixel over a valid/ready port.
//   Ports:
//     draw_clk, reset        clock, asynchronous active-high reset
//     step, grow, dir        advance request, keep-tail flag, heading
//     draw_start             request a full body pixel stream
//     px_ready               downstream accepts the pixel
//     px_valid, rx, ry       pixel output
//     px_last                final pixel of the stream
//     busy                   engine not in IDLE
//     len                    current segment count
//     collide                sticky collision flag
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    parameter int CELL      = 10,
    parameter int GRID_W    = 64,
    parameter int GRID_H    = 48,
    parameter int START_X   = 8,
    parameter int START_Y   = 24,
    parameter int WRAP      = 1
) (
    input  logic          draw_clk,
    input  logic          reset,
    input  logic          step,
    input  logic          grow,
    input  logic [1:0]    dir,
    input  logic          draw_start,
    input  logic          px_ready,
    output logic          px_valid,
    output logic [XW-1:0] rx,
    output logic [YW-1:0] ry,
    output logic          px_last,
    output logic          busy,
    output logic [LW-1:0] len,
    output logic          collide
);

    localparam int            IW      = $clog2(MAX_LEN);
    localparam logic [XW-1:0] XMAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX    = YW'(GRID_H - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_RST = LW'(START_LEN);

    state_t        state;
    dir_t          heading;
    dir_t          dir_req;
    dir_t          hd_n;
    logic          grow_q;
    logic          grow_ok;
    logic          step_go;
    logic [XW-1:0] seg_x [MAX_LEN];
    logic [YW-1:0] seg_y [MAX_LEN];
    logic [IW-1:0] chk_idx;
    logic [IW-1:0] draw_idx;
    logic [XW-1:0] nhx;
    logic [YW-1:0] nhy;
    logic          off_grid;

    logic          scan_start;
    logic [IW-1:0] scan_idx;
    logic [XW-1:0] scan_org_x;
    logic [YW-1:0] scan_org_y;
    logic          scan_last;
    logic          cell_done;

    function automatic logic [LW-1:0] ext(input logic [IW-1:0] i);
        return LW'(i);
    endfunction

    function automatic logic [XW-1:0] cell_to_px_x(input logic [XW-1:0] c);
        logic [31:0] p;
        p = 32'(c) * 32'(CELL);
        return p[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] cell_to_px_y(input logic [YW-1:0] c);
        logic [31:0] p;
        p = 32'(c) * 32'(CELL);
        return p[YW-1:0];
    endfunction

    assign busy    = (state != IDLE);
    assign dir_req = dir_t'(dir);
    assign step_go = step && !collide;
    assign grow_ok = grow_q && (len < LEN_MAX);

    // Next heading and next head cell. off_grid flags a head that left the
    // grid; with WRAP=1 the wrapped coordinate is used instead.
    always_comb begin
        hd_n     = (dir_req == opposite(heading) && len > 7'd1) ? heading : dir_req;
        nhx      = seg_x[0];
        nhy      = seg_y[0];
        off_grid = 1'b0;
        case (hd_n)
            UP: begin
                if (seg_y[0] == '0) begin
                    nhy      = YMAX;
                    off_grid = 1'b1;
                end else begin
                    nhy = seg_y[0] - YW'(1);
                end
            end
            DOWN: begin
                if (seg_y[0] == YMAX) begin
                    nhy      = '0;
                    off_grid = 1'b1;
                end else begin
                    nhy = seg_y[0] + YW'(1);
                end
            end
            LEFT: begin
                if (seg_x[0] == '0) begin
                    nhx      = XMAX;
                    off_grid = 1'b1;
                end else begin
                    nhx = seg_x[0] - XW'(1);
                end
            end
            RIGHT: begin
                if (seg_x[0] == XMAX) begin
                    nhx      = '0;
                    off_grid = 1'b1;
                end else begin
                    nhx = seg_x[0] + XW'(1);
                end
            end
            default: ;
        endcase
    end

    // The scanner is kicked from IDLE for segment 0 and again at each
    // cell_done for the following segment, so cells stream back to back.
    always_comb begin
        scan_start = 1'b0;
        scan_idx   = '0;
        if (state == IDLE && !step_go && draw_start) begin
            scan_start = 1'b1;
        end else if (state == DRAW && cell_done && ext(draw_idx) != len - 7'd1) begin
            scan_start = 1'b1;
            scan_idx   = draw_idx + IW'(1);
        end
    end

    assign scan_org_x = cell_to_px_x(seg_x[scan_idx]);
    assign scan_org_y = cell_to_px_y(seg_y[scan_idx]);
    assign scan_last  = (ext(scan_idx) == len - 7'd1);

    snake_cell_scanner #(
        .CELL(CELL)
    ) u_scan (
        .draw_clk  (draw_clk),
        .reset     (reset),
        .start     (scan_start),
        .org_x     (scan_org_x),
        .org_y     (scan_org_y),
        .last_cell (scan_last),
        .px_ready  (px_ready),
        .px_valid  (px_valid),
        .rx        (rx),
        .ry        (ry),
        .px_last   (px_last),
        .cell_done (cell_done)
    );

    always_ff @(posedge draw_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            heading  <= RIGHT;
            grow_q   <= 1'b0;
            len      <= LEN_RST;
            collide  <= 1'b0;
            chk_idx  <= '0;
            draw_idx <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < START_LEN) ? XW'(START_X - i) : '0;
                seg_y[i] <= (i < START_LEN) ? YW'(START_Y) : '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (step_go) begin
                        grow_q <= grow;
                        state  <= MOVE;
                    end else if (draw_start) begin
                        draw_idx <= '0;
                        state    <= DRAW;
                    end
                end
                MOVE: begin
                    heading <= hd_n;
                    if (off_grid && WRAP == 0) begin
                        collide <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        // Extending the shift to index len keeps the old tail.
                        for (int i = 1; i < MAX_LEN; i++) begin
                            if (LW'(i) < len || (grow_ok && LW'(i) == len)) begin
                                seg_x[i] <= seg_x[i-1];
                                seg_y[i] <= seg_y[i-1];
                            end
                        end
                        seg_x[0] <= nhx;
                        seg_y[0] <= nhy;
                        if (grow_ok) begin
                            len <= len + 7'd1;
                        end
                        chk_idx <= IW'(1);
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    // Scan always runs to the tail so step latency depends on len only.
                    if (len > 7'd1 && seg_x[0] == seg_x[chk_idx] && seg_y[0] == seg_y[chk_idx]) begin
                        collide <= 1'b1;
                    end
                    if (ext(chk_idx) >= len - 7'd1) begin
                        state <= IDLE;
                    end else begin
                        chk_idx <= chk_idx + IW'(1);
                    end
                end
                DRAW: begin
                    if (cell_done) begin
                        if (ext(draw_idx) == len - 7'd1) begin
                            state <= IDLE;
                        end else begin
                            draw_idx <= draw_idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
`timescale 1ns/1ps
module tb_snake_body_engine;

    logic draw_clk = 1'b0;
    logic reset;
    always #5 draw_clk = ~draw_clk;

    // Main instance: defaults, WRAP=1
    logic       step, grow, draw_start, px_ready;
    logic [1:0] dir;
    logic       px_valid, px_last, busy, collide;
    logic [9:0] rx;
    logic [8:0] ry;
    logic [6:0] len;

    // Second instance: length 1, no wrap, starting near the right wall
    logic       step_b, draw_b;
    logic [1:0] dir_b;
    logic       valid_b, last_b, busy_b, collide_b;
    logic [9:0] rx_b;
    logic [8:0] ry_b;
    logic [6:0] len_b;

    logic tog_en, rdy_tog;
    assign px_ready = tog_en ? rdy_tog : 1'b1;

    snake_body_engine dut (
        .draw_clk(draw_clk), .reset(reset), .step(step), .grow(grow), .dir(dir),
        .draw_start(draw_start), .px_ready(px_ready), .px_valid(px_valid),
        .rx(rx), .ry(ry), .px_last(px_last), .busy(busy), .len(len), .collide(collide)
    );

    snake_body_engine #(.START_LEN(1), .START_X(62), .WRAP(0)) dut_nowrap (
        .draw_clk(draw_clk), .reset(reset), .step(step_b), .grow(1'b0), .dir(dir_b),
        .draw_start(draw_b), .px_ready(1'b1), .px_valid(valid_b),
        .rx(rx_b), .ry(ry_b), .px_last(last_b), .busy(busy_b), .len(len_b), .collide(collide_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       last;
    } pix_t;

    pix_t exp_q[$];
    int   beats_total = 0;
    int   stream_base = 0;
    pix_t cap0, cap10, cap_last;
    logic stall_prev = 1'b0;
    pix_t stall_pix;
    pix_t mon_e;

    always @(posedge draw_clk) begin
        if (tog_en) begin
            #1 rdy_tog = ~rdy_tog;
        end
    end

    // Monitor: compares every accepted beat against the scoreboard queue
    always @(negedge draw_clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", px_valid, 1);
                check("hold_pixel", {rx, ry, px_last}, stall_pix);
            end
            stall_prev = px_valid && !px_ready;
            stall_pix  = {rx, ry, px_last};
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got (%0d,%0d), expected no beat", rx, ry);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_x", rx, mon_e.x);
                    check("pix_y", ry, mon_e.y);
                    check("pix_last", px_last, mon_e.last);
                end
                if (beats_total - stream_base == 0)  cap0  = {rx, ry, px_last};
                if (beats_total - stream_base == 10) cap10 = {rx, ry, px_last};
                cap_last = {rx, ry, px_last};
                beats_total++;
            end
        end
    end

    // Body model of the main instance (MAX_LEN 16, 64x48 grid, wrap)
    int mx[16], my[16];
    int mlen, mhd;
    bit mcol;

    task automatic model_reset();
        mlen = 3; mhd = 1; mcol = 0;
        for (int i = 0; i < 3; i++) begin
            mx[i] = 8 - i;
            my[i] = 24;
        end
    endtask

    task automatic model_step(input int d, input bit g);
        int nx, ny;
        if (mcol) return;
        if (!(d == (mhd ^ 2) && mlen > 1)) mhd = d;
        nx = mx[0];
        ny = my[0];
        case (mhd)
            0: ny = (ny == 0)  ? 47 : ny - 1;
            1: nx = (nx == 63) ? 0  : nx + 1;
            2: ny = (ny == 47) ? 0  : ny + 1;
            default: nx = (nx == 0) ? 63 : nx - 1;
        endcase
        if (g && mlen < 16) mlen++;
        for (int i = mlen - 1; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = nx;
        my[0] = ny;
        for (int i = 1; i < mlen; i++) begin
            if (mx[i] == nx && my[i] == ny) mcol = 1;
        end
    endtask

    task automatic push_expected();
        pix_t p;
        for (int s = 0; s < mlen; s++)
            for (int yy = 0; yy < 10; yy++)
                for (int xx = 0; xx < 10; xx++) begin
                    p.x    = 10'(mx[s] * 10 + xx);
                    p.y    = 9'(my[s] * 10 + yy);
                    p.last = (s == mlen - 1) && (yy == 9) && (xx == 9);
                    exp_q.push_back(p);
                end
    endtask

    task automatic do_step(input int d, input bit g, input int exp_cycles, input string nm);
        int n;
        @(posedge draw_clk); #1;
        step = 1'b1; dir = 2'(d); grow = g;
        @(posedge draw_clk); #1;
        step = 1'b0; grow = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge draw_clk); #1;
        end
        check({nm, "_busy_cycles"}, n, exp_cycles);
        model_step(d, g);
        check({nm, "_len"}, len, mlen);
        check({nm, "_collide"}, collide, mcol);
    endtask

    task automatic do_draw(input int exp_beats, input string nm);
        int n;
        push_expected();
        stream_base = beats_total;
        @(posedge draw_clk); #1;
        draw_start = 1'b1;
        @(posedge draw_clk); #1;
        draw_start = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            n++;
            @(posedge draw_clk); #1;
        end
        check({nm, "_done_in_time"}, n < 20000, 1);
        check({nm, "_beats"}, beats_total - stream_base, exp_beats);
        check({nm, "_queue_empty"}, exp_q.size(), 0);
        check({nm, "_busy_low"}, busy, 0);
        exp_q.delete();
    endtask

    task automatic step_b_task(input int d, input int exp_cycles, input string nm);
        int n;
        @(posedge draw_clk); #1;
        step_b = 1'b1; dir_b = 2'(d);
        @(posedge draw_clk); #1;
        step_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin
            n++;
            @(posedge draw_clk); #1;
        end
        check({nm, "_busy_cycles"}, n, exp_cycles);
    endtask

    task automatic draw_b_task(input int x0, input int y0, input int xl, input int yl, input string nm);
        int n, beats, fx, fy, lx, ly, ll, lastcnt;
        @(posedge draw_clk); #1;
        draw_b = 1'b1;
        @(posedge draw_clk); #1;
        draw_b = 1'b0;
        n = 0; beats = 0; fx = -1; fy = -1; lx = -1; ly = -1; ll = 0; lastcnt = 0;
        while (n < 2000) begin
            @(negedge draw_clk);
            if (valid_b) begin
                if (beats == 0) begin
                    fx = rx_b; fy = ry_b;
                end
                lx = rx_b; ly = ry_b; ll = last_b;
                if (last_b) lastcnt++;
                beats++;
            end
            if (!busy_b && !valid_b) break;
            n++;
        end
        check({nm, "_beats"}, beats, 100);
        check({nm, "_first_x"}, fx, x0);
        check({nm, "_first_y"}, fy, y0);
        check({nm, "_last_x"}, lx, xl);
        check({nm, "_last_y"}, ly, yl);
        check({nm, "_last_flag"}, ll, 1);
        check({nm, "_last_count"}, lastcnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step = 1'b0; grow = 1'b0; dir = 2'b01; draw_start = 1'b0;
        step_b = 1'b0; dir_b = 2'b01; draw_b = 1'b0;
        tog_en = 1'b0; rdy_tog = 1'b0;
        model_reset();
        repeat (3) @(posedge draw_clk);
        #1;
        check("rst_px_valid", px_valid, 0);
        check("rst_rx", rx, 0);
        check("rst_ry", ry, 0);
        check("rst_px_last", px_last, 0);
        check("rst_busy", busy, 0);
        check("rst_collide", collide, 0);
        check("rst_len", len, 3);
        check("rst_len_b", len_b, 1);
        reset = 1'b0;

        // Length-1 reversal and wall kill on the no-wrap instance
        step_b_task(3, 2, "b_rev");
        draw_b_task(610, 240, 619, 249, "b_draw_rev");
        step_b_task(1, 2, "b_r1");
        step_b_task(1, 2, "b_r2");
        step_b_task(1, 1, "b_wall");
        check("b_wall_collide", collide_b, 1);
        check("b_wall_len", len_b, 1);
        draw_b_task(630, 240, 639, 249, "b_draw_wall");
        step_b_task(1, 0, "b_ignored");
        check("b_ignored_collide", collide_b, 1);

        // Initial draw
        do_draw(300, "draw0");
        check("draw0_first", cap0, {10'd80, 9'd240, 1'b0});
        check("draw0_beat11", cap10, {10'd80, 9'd241, 1'b0});
        check("draw0_last", cap_last, {10'd69, 9'd249, 1'b1});

        // step and draw_start together: step wins, no stream
        @(posedge draw_clk); #1;
        step = 1'b1; draw_start = 1'b1; dir = 2'b01;
        @(posedge draw_clk); #1;
        step = 1'b0; draw_start = 1'b0;
        begin
            int n;
            n = 0;
            while (busy && n < 200) begin
                n++;
                @(posedge draw_clk); #1;
            end
            check("both_busy_cycles", n, 3);
        end
        model_step(1, 0);
        for (int k = 0; k < 4; k++) do_step(1, 0, 3, "right");
        do_draw(300, "draw5");
        check("after5_head", cap0, {10'd130, 9'd240, 1'b0});

        // Reversal request ignored with len>1
        do_step(3, 0, 3, "reverse");
        do_draw(300, "draw_rev");
        check("rev_head", cap0, {10'd140, 9'd240, 1'b0});

        // Growth keeps the tail
        do_step(1, 1, 4, "grow4");
        check("grow4_len", len, 4);
        do_draw(400, "draw_grow");
        check("grow_head", cap0, {10'd150, 9'd240, 1'b0});
        check("grow_tail", cap_last, {10'd129, 9'd249, 1'b1});
        for (int k = 5; k <= 16; k++) do_step(1, 1, k, "grow");
        check("grow_len16", len, 16);
        do_step(1, 1, 16, "grow_sat");
        check("grow_sat_len", len, 16);

        // Walk to the right edge and wrap
        for (int k = 0; k < 35; k++) do_step(1, 0, 16, "walk");
        do_draw(1600, "draw_edge");
        check("edge_head", cap0, {10'd630, 9'd240, 1'b0});
        do_step(1, 0, 16, "wrap");
        do_draw(1600, "draw_wrap");
        check("wrap_head", cap0, {10'd0, 9'd240, 1'b0});

        // Backpressure
        tog_en = 1'b1;
        do_draw(1600, "draw_bp");
        tog_en = 1'b0;
        check("bp_head", cap0, {10'd0, 9'd240, 1'b0});

        // Reset in the middle of a stream
        push_expected();
        stream_base = beats_total;
        @(posedge draw_clk); #1;
        draw_start = 1'b1;
        @(posedge draw_clk); #1;
        draw_start = 1'b0;
        repeat (50) @(posedge draw_clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_px_valid", px_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_len", len, 3);
        check("midrst_collide", collide, 0);
        check("midrst_rx", rx, 0);
        exp_q.delete();
        model_reset();
        @(posedge draw_clk);
        @(posedge draw_clk); #1;
        reset = 1'b0;
        do_draw(300, "draw_after_rst");
        check("after_rst_first", cap0, {10'd80, 9'd240, 1'b0});
        check("after_rst_last", cap_last, {10'd69, 9'd249, 1'b1});

        // Self-collision
        do_step(1, 1, 4, "sc_g1");
        do_step(1, 1, 5, "sc_g2");
        do_step(0, 0, 5, "sc_up");
        do_step(3, 0, 5, "sc_left");
        check("sc_pre_collide", collide, 0);
        do_step(2, 0, 5, "sc_down");
        check("sc_collide", collide, 1);
        do_step(1, 0, 0, "sc_ignored");
        check("sc_ignored_collide", collide, 1);
        do_draw(500, "draw_sc");
        check("sc_head", cap0, {10'd90, 9'd240, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
- Parametrised successor to the fixed-length snake block.
- Stores up to MAX_LEN body segments as grid-cell coordinates.
- Advances the body one cell per step request, with optional growth, reversal rejection, wall wrap or wall kill, and sequential self-collision checking.
- Streams every body pixel to the frame-buffer writer over a valid/ready handshake. Sits between game control (step/grow/dir) and the VGA frame-buffer write port.

Parameters:
- MAX_LEN, 16: maximum segments; 2..64.
- START_LEN, 3: length after reset; 1..MAX_LEN.
- CELL, 10: cell edge in pixels; 1..16.
- GRID_W, 64: grid columns; GRID_W*CELL <= 1024.
- GRID_H, 48: grid rows; GRID_H*CELL <= 512.
- START_X, 8: head column after reset; >= START_LEN-1.
- START_Y, 24: head row after reset.
- WRAP, 1: 1 = edges wrap around; 0 = leaving the grid is a collision.

Ports:
- draw_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- step  in  1  one-cycle request to advance one cell.
- grow  in  1  sampled with accepted step; keep tail (length+1).
- dir  in  2  requested heading: 00 up, 01 right, 10 down, 11 left.
- draw_start  in  1  one-cycle request to stream all body pixels.
- px_ready  in  1  downstream accepts the pixel.
- px_valid  out  1  rx/ry hold a valid pixel.
- rx  out  10  pixel x.
- ry  out  9  pixel y.
- px_last  out  1  high with the final pixel of a stream.
- busy  out  1  high in any state other than IDLE.
- len  out  7  current segment count.
- collide  out  1  sticky collision flag.

Behaviour:
- Reset values (asynchronous):
  - State IDLE; px_valid=0, rx=0, ry=0, px_last=0, busy=0, collide=0.
  - len=START_LEN; heading=01 (right).
  - Segment i=(START_X-i, START_Y) for i < START_LEN.
- Reset mid-operation aborts immediately; px_valid drops in the same instant, and no partial step is retained.
- States: IDLE, MOVE, CHECK, DRAW.
- IDLE transitions:
  - step && !collide goes to MOVE.
  - Otherwise draw_start goes to DRAW.
  - If step and draw_start arrive in the same cycle, step wins and draw_start is dropped.
  - Requests arriving while busy=1 are ignored; no queueing.
  - When collide=1, step is ignored but draw is still allowed.
- Heading update, one cycle in MOVE:
  - If dir is the opposite of the current heading and len>1, keep the current heading. Otherwise heading<=dir.
  - New head = segment 0 moved one cell along the heading.
- Edges:
  - WRAP=1: x GRID_W-1 -> 0 and 0 -> GRID_W-1; same for y with GRID_H.
  - WRAP=0: an off-grid head sets collide, leaves the body unchanged and goes to IDLE.
- Shift: segment[i] <= segment[i-1] for i=1..len-1, and segment[0] <= new head.
- Growth: if grow && len<MAX_LEN, segment[len] <= old segment[len-1] and len increments. At len==MAX_LEN, grow is ignored and a plain shift occurs.
- CHECK:
  - Compare segment[0] against segments 1..len-1, one per cycle.
  - The first match sets collide; the scan continues to completion for fixed latency.
  - len==1 takes one cycle with no compare.
  - Then go to IDLE.
- Step latency: busy high for 1 + max(1, len-1) cycles after the accepting edge.
- DRAW order:
  - Segment 0 to len-1; inside each cell, row-major with px fastest, 0..CELL-1.
  - rx = seg_x*CELL + px; ry = seg_y*CELL + py.
  - Stream is exactly len*CELL*CELL beats.
- DRAW handshake:
  - The first pixel is presented the cycle after entry.
  - rx, ry, px_last and px_valid are registered and held stable while px_valid && !px_ready.
  - The counters advance only on px_valid && px_ready.
  - After the last beat is accepted, px_valid=0 and the state returns to IDLE on the next cycle.
- The body never changes during DRAW because step is ignored while busy.

Decomposition:
- snake_pkg holds:
  - dir_t enum (UP, RIGHT, DOWN, LEFT).
  - state_t enum.
  - Function opposite(dir_t).
  - Constants SCREEN_W=640 and SCREEN_H=480.
- One sub-module, snake_cell_scanner: takes a CELL parameter, the cell origin and start, and owns px/py counters plus the valid/ready output register. It returns cell_done. The engine steps the segment index.

Test Plan:
- Reset release, then draw_start with px_ready=1:
  - 300 beats (3*10*10).
  - First pixel (80,240); beat 11 is (80,241); last beat is (69,249) with px_last=1.
  - busy falls afterwards.
- After reset, dir=01 with 5 steps: head (13,24), len=3, collide=0, and each step holds busy for 3 cycles.
- Growth:
  - Step with grow=1: len becomes 4, tail retained.
  - Repeat up to MAX_LEN=16, then another grow step: len stays 16.
- Reversal: heading right, dir=11 step gives head x+1; with len=1 the same stimulus gives head x-1.
- Edge handling:
  - WRAP=1: head (63,24) moving right becomes (0,24).
  - WRAP=0: the same move sets collide, body unchanged, and later steps are ignored.
- Backpressure and reset:
  - Toggle px_ready every other cycle: each rx/ry held until accepted, and the beat count is unchanged.
  - Assert reset mid-stream: px_valid=0 immediately, and state and body match reset values.
- Self-collision: len=5, steps up, left, down → collide=1, latency 5 cycles.
